// File: rtl/global_vcfg_responder.sv
// Answers CVA6 vset* requests with the globally committed vl/vill a cycle after
// the dispatcher updates them; all other accelerator requests are absorbed silently.
package global_vcfg_responder_pkg;
  localparam int unsigned XLEN      = 64;
  localparam logic [6:0]  OpcodeVec = 7'b1010111;
  localparam logic [2:0]  OPCFG     = 3'b111;

  typedef struct packed {
    logic       vill;
    logic       vma;
    logic       vta;
    logic [2:0] vsew;
    logic [2:0] vlmul;
  } vtype_t;
endpackage

module global_vcfg_responder
  import global_vcfg_responder_pkg::*;
#(
  parameter int unsigned NrLanes     = 0,
  parameter int unsigned NrClusters  = 0,
  parameter type         vlen_cl_t   = logic,
  parameter int unsigned TransIdBits = 3,
  parameter int unsigned Depth       = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   acc_req_valid_i,
  output logic                   acc_req_ready_o,
  input  logic [31:0]            acc_insn_i,
  input  logic [TransIdBits-1:0] acc_trans_id_i,
  input  vlen_cl_t               vl_i,
  input  vtype_t                 vtype_i,
  output logic                   acc_resp_valid_o,
  input  logic                   acc_resp_ready_i,
  output logic [XLEN-1:0]        acc_resp_result_o,
  output logic [TransIdBits-1:0] acc_resp_trans_id_o,
  output logic                   acc_resp_vill_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 2);

  typedef struct packed {
    logic [XLEN-1:0]        result;
    logic                   vill;
    logic [TransIdBits-1:0] id;
  } entry_t;

  logic                   cap_valid;
  logic [TransIdBits-1:0] cap_id;
  logic [CntW-1:0]        count;
  logic [PtrW-1:0]        rd_ptr;
  logic [PtrW-1:0]        wr_ptr;
  entry_t                 mem [Depth];

  logic   is_vset;
  logic   accept_vset;
  logic   push;
  logic   pop;
  entry_t push_entry;
  entry_t head;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign is_vset     = (acc_insn_i[6:0] == OpcodeVec) && (acc_insn_i[14:12] == OPCFG);
  // No credit for a same-cycle pop keeps ready off the response-ready path.
  assign acc_req_ready_o = (count + CntW'(cap_valid)) < CntW'(Depth);
  assign accept_vset = acc_req_valid_i && acc_req_ready_o && is_vset;

  // vl/vtype are sampled one cycle after acceptance, once the dispatcher has committed them.
  assign push = cap_valid;
  assign push_entry.result = vtype_i.vill ? '0 : XLEN'(vl_i);
  assign push_entry.vill   = vtype_i.vill;
  assign push_entry.id     = cap_id;

  assign acc_resp_valid_o = (count != '0);
  assign pop              = acc_resp_valid_o && acc_resp_ready_i;

  assign head                = acc_resp_valid_o ? mem[rd_ptr] : '0;
  assign acc_resp_result_o   = head.result;
  assign acc_resp_vill_o     = head.vill;
  assign acc_resp_trans_id_o = head.id;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cap_valid <= 1'b0;
      cap_id    <= '0;
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
    end else begin
      cap_valid <= accept_vset;
      if (accept_vset) cap_id <= acc_trans_id_i;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + CntW'(1);
      else if (pop && !push) count <= count - CntW'(1);
    end
  end

  // Storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  logic unused_cfg;
  assign unused_cfg = ^{32'(NrLanes), 32'(NrClusters), acc_insn_i[31:15], acc_insn_i[11:7],
                        vtype_i.vma, vtype_i.vta, vtype_i.vsew, vtype_i.vlmul};

endmodule

// File: tb/tb_global_vcfg_responder.sv
// Directed bench for global_vcfg_responder with a response scoreboard.
module tb_global_vcfg_responder;
  import global_vcfg_responder_pkg::*;

  typedef logic [15:0] vl_t;
  typedef struct packed {
    logic [63:0] result;
    logic [2:0]  id;
    logic        vill;
  } exp_t;

  localparam logic [31:0] VSETVLI = 32'h0000_7057;
  localparam logic [31:0] VLOAD   = 32'h0000_0007;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_insn = '0;
  logic [2:0]  req_id = '0;
  vl_t         vl = '0;
  vtype_t      vtype = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [63:0] resp_result;
  logic [2:0]  resp_id;
  logic        resp_vill;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  global_vcfg_responder #(
    .NrLanes(4), .NrClusters(4), .vlen_cl_t(vl_t), .TransIdBits(3), .Depth(2)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .acc_req_valid_i(req_valid), .acc_req_ready_o(req_ready),
    .acc_insn_i(req_insn), .acc_trans_id_i(req_id),
    .vl_i(vl), .vtype_i(vtype),
    .acc_resp_valid_o(resp_valid), .acc_resp_ready_i(resp_ready),
    .acc_resp_result_o(resp_result), .acc_resp_trans_id_o(resp_id),
    .acc_resp_vill_o(resp_vill)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endfunction

  // Every visible response must match the scoreboard head, stalled or not.
  always @(negedge clk) begin
    if (rst_n && resp_valid) begin
      chk("resp_expected", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        chk("resp_result", resp_result, sb[0].result);
        chk("resp_id", 64'(resp_id), 64'(sb[0].id));
        chk("resp_vill", 64'(resp_vill), 64'(sb[0].vill));
        if (resp_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [31:0] insn, input logic [2:0] id, input logic vset,
                     input vl_t new_vl, input logic new_vill);
    logic acc;
    exp_t e;
    acc = 1'b0;
    req_valid = 1'b1;
    req_insn  = insn;
    req_id    = id;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = req_ready;
      step();
    end
    req_valid = 1'b0;
    chk("req_accepted", 64'(acc), 64'd1);
    if (acc && vset) begin
      e.result = new_vill ? 64'd0 : 64'(new_vl);
      e.id     = id;
      e.vill   = new_vill;
      sb.push_back(e);
      vl         = new_vl;
      vtype.vill = new_vill;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_valid", 64'(resp_valid), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_result", resp_result, 64'd0);
    chk("rst_id", 64'(resp_id), 64'd0);
    chk("rst_vill", 64'(resp_vill), 64'd0);
    rst_n = 1'b1;
    step();

    // Single vsetvli, two-cycle latency, one-cycle response
    resp_ready = 1'b1;
    req(VSETVLI, 3'd5, 1'b1, 16'd16, 1'b0);
    @(negedge clk);
    chk("lat_t1_valid", 64'(resp_valid), 64'd0);
    step();
    @(negedge clk);
    chk("lat_t2_valid", 64'(resp_valid), 64'd1);
    step();
    @(negedge clk);
    chk("lat_t3_valid", 64'(resp_valid), 64'd0);
    chk("single_done", 64'(sb.size()), 64'd0);

    // Back-to-back with response backpressure
    step();
    resp_ready = 1'b0;
    req(VSETVLI, 3'd1, 1'b1, 16'd8, 1'b0);
    req(VSETVLI, 3'd2, 1'b1, 16'd32, 1'b0);
    @(negedge clk);
    chk("b2b_ready_t2", 64'(req_ready), 64'd0);
    step();
    @(negedge clk);
    chk("b2b_ready_t3", 64'(req_ready), 64'd0);
    step();
    resp_ready = 1'b1;
    drain();

    // Non-vset request: absorbed, no response
    req(VLOAD, 3'd6, 1'b0, 16'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("nonvset_valid", 64'(resp_valid), 64'd0);
      chk("nonvset_ready", 64'(req_ready), 64'd1);
      step();
    end

    // Illegal vtype
    req(VSETVLI, 3'd3, 1'b1, 16'd0, 1'b1);
    drain();
    vtype.vill = 1'b0;

    // Full FIFO with toggling response ready
    resp_ready = 1'b0;
    req(VSETVLI, 3'd4, 1'b1, 16'd10, 1'b0);
    req(VSETVLI, 3'd5, 1'b1, 16'd20, 1'b0);
    @(negedge clk);
    chk("full_ready", 64'(req_ready), 64'd0);
    step();
    fork
      begin
        repeat (16) begin
          step();
          resp_ready = ~resp_ready;
        end
        resp_ready = 1'b1;
      end
      begin
        req(VSETVLI, 3'd6, 1'b1, 16'd30, 1'b0);
        req(VSETVLI, 3'd7, 1'b1, 16'd40, 1'b0);
        req(VLOAD,   3'd0, 1'b0, 16'd0,  1'b0);
        req(VSETVLI, 3'd1, 1'b1, 16'd50, 1'b0);
      end
    join
    drain();

    // Reset with one buffered entry and one capture in flight
    resp_ready = 1'b0;
    req(VSETVLI, 3'd1, 1'b1, 16'd5, 1'b0);
    req(VSETVLI, 3'd2, 1'b1, 16'd6, 1'b0);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("midrst_valid", 64'(resp_valid), 64'd0);
    chk("midrst_ready", 64'(req_ready), 64'd1);
    chk("midrst_result", resp_result, 64'd0);
    step();
    rst_n = 1'b1;
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("postrst_valid", 64'(resp_valid), 64'd0);
      step();
    end

    chk("sb_final_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/global_vcfg_responder.md
GLOBAL_VCFG_RESPONDER -- requirements
Module: global_vcfg_responder

Interface
REQ-001 SHALL have parameter NrLanes, default 0, lanes per cluster (only used to size vlen_cl_t; not used functionally).
REQ-002 SHALL have parameter NrClusters, default 0, number of clusters (only used to size vlen_cl_t; not used functionally).
REQ-003 SHALL have parameter vlen_cl_t, default logic, global vector-length type.
REQ-004 SHALL have parameter TransIdBits, default 3, transaction-id width.
REQ-005 SHALL have parameter Depth, default 2, response buffer entries (>=1).
REQ-006 SHALL have port clk_i  input  1  single clock.
REQ-007 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-008 SHALL have port acc_req_valid_i  input  1  CVA6 accelerator request valid.
REQ-009 SHALL have port acc_req_ready_o  output  1  request accepted when valid and ready are both high.
REQ-010 SHALL have port acc_insn_i  input  32  request instruction word.
REQ-011 SHALL have port acc_trans_id_i  input  TransIdBits  request transaction id.
REQ-012 SHALL have port vl_i  input  $bits(vlen_cl_t)  registered global vl from the global dispatcher.
REQ-013 SHALL have port vtype_i  input  vtype_t  registered global vtype from the global dispatcher.
REQ-014 SHALL have port acc_resp_valid_o  output  1  response valid.
REQ-015 SHALL have port acc_resp_ready_i  input  1  CVA6 response ready.
REQ-016 SHALL have port acc_resp_result_o  output  riscv::XLEN  new vl, zero-extended.
REQ-017 SHALL have port acc_resp_trans_id_o  output  TransIdBits  id of the answered request.
REQ-018 SHALL have port acc_resp_vill_o  output  1  vill of the vtype in effect after the instruction.

Function
REQ-019 SHALL classify an accepted request as vset* iff insn[6:0]==riscv::OpcodeVec and insn[14:12]==OPCFG; all other requests SHALL be accepted (when ready) and produce no response.
REQ-020 SHALL, on acceptance of a vset* request in cycle T, load a capture stage (valid bit + trans_id).
REQ-021 SHALL, in cycle T+1, push {vl_i, vtype_i.vill, captured trans_id} into the buffer, because the dispatcher updates vl/vtype at the T->T+1 edge.
REQ-022 SHALL implement the buffer as a FIFO of Depth entries with registered outputs; acc_resp_valid_o SHALL be high iff the FIFO is non-empty, so minimum request-to-response latency is 2 cycles.
REQ-023 SHALL pop the head only when acc_resp_valid_o and acc_resp_ready_i are both high; the head SHALL be held stable while valid && !ready.
REQ-024 SHALL allow a new vset* capture in the same cycle as a push of the previous capture (back-to-back, one per cycle).
REQ-025 SHALL drive acc_req_ready_o = (fifo_count + capture_valid) < Depth, with no credit taken for a same-cycle pop.
REQ-026 SHALL, on a simultaneous push and pop, keep the count unchanged and preserve order; read and write pointers SHALL wrap modulo Depth.
REQ-027 SHALL zero-extend the vl result to riscv::XLEN; a vill vtype SHALL yield result 0 and vill 1.
REQ-028 SHALL never drop, duplicate or reorder responses relative to request acceptance order.

Reset
REQ-029 SHALL, on rst_ni low (asynchronous), clear the capture valid bit, the FIFO count and both pointers; in-flight requests SHALL be discarded.
REQ-030 SHALL hold these reset output values: acc_resp_valid_o=0, acc_req_ready_o=1, acc_resp_result_o=0, acc_resp_trans_id_o=0, acc_resp_vill_o=0.

Verification
REQ-031 SHALL cover single vsetvli: id 5 accepted at T, vl_i=16 at T+1, resp_ready=1 -> response valid at T+2 with result 16, id 5, vill 0, for exactly one cycle.
REQ-032 SHALL cover back-to-back: vset* ids 1 and 2 at T and T+1 with vl_i 8 then 32, resp_ready=0 -> ready_o low from T+2; after release, responses (1,8) then (2,32).
REQ-033 SHALL cover non-vset: vector load request at T -> no response; ready_o stays 1.
REQ-034 SHALL cover illegal vtype: vill=1, vl_i=0 at T+1 -> response with result 0, vill 1.
REQ-035 SHALL cover stall: FIFO full (Depth=2) with resp_ready toggling 0/1 -> a pop and a new acceptance in the same cycle keep order, head stable while stalled, no loss.
REQ-036 SHALL cover reset mid-operation: rst_ni low with one capture and one buffered entry -> next cycle resp_valid_o=0, ready_o=1, and no stale response after reset is released.
